multdiv_issue_ctrl: RTL and testbench

- Initiator-side controller for the iterative multiply/divide unit.
- Accepts one MULT/DIV request from the execute stage and drives the unit's operand and start-pulse interface.
- Holds operands stable and stalls the pipeline until the unit's ready pulse arrives.
- Then delivers a registered writeback: result, destination register and exception flag.

---
 rtl/multdiv_issue_ctrl.sv | 168 ++++++++++++++++
 tb/tb_multdiv_issue_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_issue_ctrl.sv
// Issue controller for the iterative multiply/divide unit: latches one request, pulses start,
// stalls until the unit's ready pulse, then presents a one-cycle registered writeback.
// Optional macro MULTDIV_TIMEOUT_EN adds a WAIT watchdog and the sticky timeout_seen output.
module multdiv_issue_ctrl #(
   parameter int TIMEOUT_CYCLES = 40,
   parameter int CNT_W          = 6
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        issue_valid,
   input  logic        issue_is_div,
   input  logic [31:0] issue_opA,
   input  logic [31:0] issue_opB,
   input  logic [4:0]  issue_rd,
   output logic        issue_ready,
   input  logic        flush,
   output logic        stall,
   output logic [31:0] md_operandA,
   output logic [31:0] md_operandB,
   output logic        md_ctrl_MULT,
   output logic        md_ctrl_DIV,
   input  logic [31:0] md_result,
   input  logic        md_exception,
   input  logic        md_resultRDY,
   output logic        wb_valid,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        wb_exception
`ifdef MULTDIV_TIMEOUT_EN
   ,
   output logic        timeout_seen
`endif
);

   typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

   state_t      state_q, state_d;
   logic [31:0] opA_q, opB_q;
   logic [4:0]  rd_q;
   logic        multPulse_q, divPulse_q;
   logic        wbValid_q;
   logic [4:0]  wbRd_q;
   logic [31:0] wbData_q;
   logic        wbExc_q;
   logic        accept;
   logic        captureResult;
   logic        captureTimeout;

   // The counter must be able to represent the timeout threshold.
   if (2 ** CNT_W <= TIMEOUT_CYCLES) begin : gBadCntWidth
      $error("multdiv_issue_ctrl: CNT_W too narrow for TIMEOUT_CYCLES");
   end

`ifdef MULTDIV_TIMEOUT_EN
   logic [CNT_W-1:0] cnt_q;
   logic             timeoutSeen_q;
   logic             cntExpired;

   assign cntExpired   = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
   assign timeout_seen = timeoutSeen_q;
`endif

   // Next-state logic; flush always wins over the unit's ready pulse.
   always_comb begin
      state_d        = state_q;
      accept         = 1'b0;
      captureResult  = 1'b0;
      captureTimeout = 1'b0;
      case (state_q)
         IDLE: begin
            if (issue_valid && !flush) begin
               accept  = 1'b1;
               state_d = START;
            end
         end
         START: begin
            state_d = flush ? IDLE : WAIT;
         end
         WAIT: begin
            if (flush) begin
               state_d = IDLE;
            end else if (md_resultRDY) begin
               captureResult = 1'b1;
               state_d       = DONE;
            end
`ifdef MULTDIV_TIMEOUT_EN
            else if (cntExpired) begin
               captureTimeout = 1'b1;
               state_d        = DONE;
            end
`endif
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Start pulses are registered off the accept decision, so they are high exactly during START.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         opA_q       <= '0;
         opB_q       <= '0;
         rd_q        <= '0;
         multPulse_q <= 1'b0;
         divPulse_q  <= 1'b0;
         wbValid_q   <= 1'b0;
         wbRd_q      <= '0;
         wbData_q    <= '0;
         wbExc_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         multPulse_q <= accept && !issue_is_div;
         divPulse_q  <= accept && issue_is_div;
         wbValid_q   <= (state_d == DONE);
         if (accept) begin
            opA_q <= issue_opA;
            opB_q <= issue_opB;
            rd_q  <= issue_rd;
         end
         if (captureResult) begin
            wbData_q <= md_result;
            wbExc_q  <= md_exception;
            wbRd_q   <= rd_q;
         end else if (captureTimeout) begin
            wbData_q <= '0;
            wbExc_q  <= 1'b1;
            wbRd_q   <= rd_q;
         end
      end
   end

`ifdef MULTDIV_TIMEOUT_EN
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q         <= '0;
         timeoutSeen_q <= 1'b0;
      end else begin
         if (state_q == START) begin
            cnt_q <= '0;
         end else if (state_q == WAIT) begin
            cnt_q <= cnt_q + 1'b1;
         end
         if (captureTimeout) begin
            timeoutSeen_q <= 1'b1;
         end
      end
   end
`endif

   assign issue_ready  = (state_q == IDLE);
   assign stall        = ((state_q == IDLE) && issue_valid && !flush)
                         || (state_q == START) || (state_q == WAIT);
   assign md_operandA  = opA_q;
   assign md_operandB  = opB_q;
   assign md_ctrl_MULT = multPulse_q;
   assign md_ctrl_DIV  = divPulse_q;
   // A flush arriving during DONE squashes the already-registered strobe.
   assign wb_valid     = wbValid_q && !flush;
   assign wb_rd        = wbRd_q;
   assign wb_data      = wbData_q;
   assign wb_exception = wbExc_q;

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// Directed self-checking bench for multdiv_issue_ctrl with a behavioural stub of the
// iterative unit (MULT ready 16 edges after the start edge, DIV 32).
module tb_multdiv_issue_ctrl;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        issue_valid, issue_is_div;
   logic [31:0] issue_opA, issue_opB;
   logic [4:0]  issue_rd;
   logic        issue_ready, flush, stall;
   logic [31:0] md_operandA, md_operandB;
   logic        md_ctrl_MULT, md_ctrl_DIV;
   logic [31:0] md_result;
   logic        md_exception, md_resultRDY;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        wb_exception;
`ifdef MULTDIV_TIMEOUT_EN
   logic        timeout_seen;
`endif

   int tests = 0;
   int fails = 0;

   always #5 clock = ~clock;

   multdiv_issue_ctrl dut (
      .clock(clock), .reset_n(reset_n),
      .issue_valid(issue_valid), .issue_is_div(issue_is_div),
      .issue_opA(issue_opA), .issue_opB(issue_opB), .issue_rd(issue_rd),
      .issue_ready(issue_ready), .flush(flush), .stall(stall),
      .md_operandA(md_operandA), .md_operandB(md_operandB),
      .md_ctrl_MULT(md_ctrl_MULT), .md_ctrl_DIV(md_ctrl_DIV),
      .md_result(md_result), .md_exception(md_exception), .md_resultRDY(md_resultRDY),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_exception(wb_exception)
`ifdef MULTDIV_TIMEOUT_EN
      , .timeout_seen(timeout_seen)
`endif
   );

   // Behavioural unit: computes combinationally from the held operands, pulses ready once.
   bit   stubBusy = 0, stubMute = 0, stubIsDiv = 0, seenM = 0, seenD = 0;
   int   stubRemain = 0;
   logic stubRdy = 1'b0, forceRdy = 1'b0;

   function automatic logic [32:0] unitCalc(input bit isDiv, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] prod;
      logic [31:0] res;
      if (!isDiv) begin
         prod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
         res  = prod[31:0];
         return {(prod != {{32{res[31]}}, res}), res};
      end
      if (b == 32'd0) return {1'b1, 32'd0};
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, 32'h8000_0000};
      res = $signed(a) / $signed(b);
      return {1'b0, res};
   endfunction

   assign {md_exception, md_result} = unitCalc(stubIsDiv, md_operandA, md_operandB);
   assign md_resultRDY = stubRdy | forceRdy;

   always @(negedge clock) begin
      seenM = md_ctrl_MULT;
      seenD = md_ctrl_DIV;
   end

   always @(posedge clock) begin
      #1;
      stubRdy = 1'b0;
      if (seenM || seenD) begin
         stubBusy   = 1;
         stubIsDiv  = seenD;
         stubRemain = seenD ? 30 : 14;
         seenM      = 0;
         seenD      = 0;
      end else if (stubBusy) begin
         stubRemain--;
         if (stubRemain == 0) begin
            stubBusy = 0;
            if (!stubMute) stubRdy = 1'b1;
         end
      end
   end

   // Drives one request and observes it cycle by cycle; cycle 1 is the acceptance cycle.
   task automatic do_op(input bit isDiv, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                        input int flushAt, input int maxCyc,
                        output int lat, output int wbCnt, output int stallCnt, output int multCnt,
                        output int divCnt, output int pulseCyc, output bit opsHeld,
                        output logic [31:0] data, output logic [4:0] wrd, output logic exc,
                        output logic readyAtWb);
      lat = 0; wbCnt = 0; stallCnt = 0; multCnt = 0; divCnt = 0; pulseCyc = 0; opsHeld = 1;
      data = 'x; wrd = 'x; exc = 1'bx; readyAtWb = 1'bx;
      @(negedge clock);
      issue_valid = 1'b1; issue_is_div = isDiv; issue_opA = a; issue_opB = b; issue_rd = rd;
      for (int cyc = 1; cyc <= maxCyc; cyc++) begin
         flush = (cyc == flushAt);
         #1;
         if (stall) stallCnt++;
         if (md_ctrl_MULT) begin multCnt++; pulseCyc = cyc; end
         if (md_ctrl_DIV) begin divCnt++; pulseCyc = cyc; end
         if (cyc >= 2 && lat == 0 && flushAt == 0 && (md_operandA !== a || md_operandB !== b)) opsHeld = 0;
         if (wb_valid === 1'b1) begin
            wbCnt++;
            if (lat == 0) begin
               lat = cyc; data = wb_data; wrd = wb_rd; exc = wb_exception; readyAtWb = issue_ready;
            end
         end
         @(negedge clock);
         issue_valid = 1'b0; flush = 1'b0;
         issue_opA = ~a; issue_opB = ~b; issue_rd = ~rd;
         if (lat != 0 && flushAt == 0) break;
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      #2;
      tests++; if (issue_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_issue_ready: got %b, expected 1", issue_ready); end
      tests++; if (stall !== 1'b0) begin fails++; $display("[TB] FAIL reset_stall: got %b, expected 0", stall); end
      tests++; if ({md_ctrl_MULT, md_ctrl_DIV, wb_valid, wb_exception} !== 4'b0) begin fails++;
         $display("[TB] FAIL reset_flags: got %b, expected 0000", {md_ctrl_MULT, md_ctrl_DIV, wb_valid, wb_exception}); end
      tests++; if ({md_operandA, md_operandB, wb_data, wb_rd} !== '0) begin fails++;
         $display("[TB] FAIL reset_data: got %h %h %h %h, expected all 0", md_operandA, md_operandB, wb_data, wb_rd); end
`ifdef MULTDIV_TIMEOUT_EN
      tests++; if (timeout_seen !== 1'b0) begin fails++; $display("[TB] FAIL reset_timeout_seen: got %b, expected 0", timeout_seen); end
`endif
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   task automatic test_mult();
      int lat, wbc, st, mc, dc, pc; bit held; logic [31:0] d; logic [4:0] r; logic e, rdy;
      do_op(0, 32'd7, 32'hFFFF_FFFD, 5'd5, 0, 60, lat, wbc, st, mc, dc, pc, held, d, r, e, rdy);
      tests++; if (lat !== 18) begin fails++; $display("[TB] FAIL mult_latency: got %0d, expected 18", lat); end
      tests++; if (st !== 17) begin fails++; $display("[TB] FAIL mult_stall_cycles: got %0d, expected 17", st); end
      tests++; if (mc !== 1 || dc !== 0 || pc !== 2) begin fails++;
         $display("[TB] FAIL mult_pulse: got mult=%0d div=%0d at cycle %0d, expected 1 0 at 2", mc, dc, pc); end
      tests++; if ({e, r, d} !== {1'b0, 5'd5, 32'hFFFF_FFEB}) begin fails++;
         $display("[TB] FAIL mult_wb: got exc=%b rd=%0d data=%h, expected 0 5 ffffffeb", e, r, d); end
      tests++; if (rdy !== 1'b0) begin fails++; $display("[TB] FAIL mult_ready_in_done: got %b, expected 0", rdy); end
   endtask

   task automatic test_flush_vs_ready();
      int lat, wbc, st, mc, dc, pc; bit held; logic [31:0] d; logic [4:0] r; logic e, rdy;
      do_op(0, 32'd5, 32'd6, 5'd9, 17, 24, lat, wbc, st, mc, dc, pc, held, d, r, e, rdy);
      tests++; if (wbc !== 0) begin fails++; $display("[TB] FAIL flush_vs_ready_wb: got %0d strobes, expected 0", wbc); end
      #1;
      tests++; if (wb_data !== 32'hFFFF_FFEB) begin fails++; $display("[TB] FAIL flush_vs_ready_hold: got %h, expected ffffffeb", wb_data); end
   endtask

   task automatic test_div();
      int lat, wbc, st, mc, dc, pc; bit held; logic [31:0] d; logic [4:0] r; logic e, rdy;
      do_op(1, 32'd100, 32'hFFFF_FFF9, 5'd17, 0, 80, lat, wbc, st, mc, dc, pc, held, d, r, e, rdy);
      tests++; if (lat !== 34) begin fails++; $display("[TB] FAIL div_latency: got %0d, expected 34", lat); end
      tests++; if (dc !== 1 || mc !== 0 || pc !== 2) begin fails++;
         $display("[TB] FAIL div_pulse: got div=%0d mult=%0d at cycle %0d, expected 1 0 at 2", dc, mc, pc); end
      tests++; if (held !== 1'b1) begin fails++; $display("[TB] FAIL div_operands_held: got %b, expected 1", held); end
      tests++; if ({e, r, d} !== {1'b0, 5'd17, 32'hFFFF_FFF2}) begin fails++;
         $display("[TB] FAIL div_wb: got exc=%b rd=%0d data=%h, expected 0 17 fffffff2", e, r, d); end
   endtask

   task automatic test_exceptions();
      int lat, wbc, st, mc, dc, pc; bit held; logic [31:0] d; logic [4:0] r; logic e, rdy;
      do_op(1, 32'd55, 32'd0, 5'd3, 0, 80, lat, wbc, st, mc, dc, pc, held, d, r, e, rdy);
      tests++; if ({lat, e, d} !== {32'd34, 1'b1, 32'd0}) begin fails++;
         $display("[TB] FAIL div_by_zero: got lat=%0d exc=%b data=%h, expected 34 1 0", lat, e, d); end
      do_op(0, 32'h4000_0000, 32'd4, 5'd4, 0, 60, lat, wbc, st, mc, dc, pc, held, d, r, e, rdy);
      tests++; if ({lat, e, d} !== {32'd18, 1'b1, 32'd0}) begin fails++;
         $display("[TB] FAIL mult_overflow: got lat=%0d exc=%b data=%h, expected 18 1 0", lat, e, d); end
   endtask

   task automatic test_flush_wait();
      int lat, wbc, st, mc, dc, pc; bit held; logic [31:0] d; logic [4:0] r; logic e, rdy;
      do_op(1, 32'd90, 32'd9, 5'd8, 12, 13, lat, wbc, st, mc, dc, pc, held, d, r, e, rdy);
      tests++; if (wbc !== 0) begin fails++; $display("[TB] FAIL flush_wait_wb: got %0d strobes, expected 0", wbc); end
      #1;
      tests++; if (issue_ready !== 1'b1) begin fails++; $display("[TB] FAIL flush_wait_idle: got %b, expected 1", issue_ready); end
      do_op(0, 32'd3, 32'd4, 5'd12, 0, 60, lat, wbc, st, mc, dc, pc, held, d, r, e, rdy);
      tests++; if ({lat, r, d} !== {32'd18, 5'd12, 32'd12}) begin fails++;
         $display("[TB] FAIL flush_then_mult: got lat=%0d rd=%0d data=%h, expected 18 12 0000000c", lat, r, d); end
   endtask

   task automatic test_flush_done();
      int lat, wbc, st, mc, dc, pc; bit held; logic [31:0] d; logic [4:0] r; logic e, rdy;
      do_op(0, 32'd2, 32'd3, 5'd1, 18, 22, lat, wbc, st, mc, dc, pc, held, d, r, e, rdy);
      tests++; if (wbc !== 0) begin fails++; $display("[TB] FAIL flush_done_wb: got %0d strobes, expected 0", wbc); end
      #1;
      tests++; if (issue_ready !== 1'b1) begin fails++; $display("[TB] FAIL flush_done_idle: got %b, expected 1", issue_ready); end
   endtask

   task automatic test_flush_idle();
      @(negedge clock);
      issue_valid = 1'b1; issue_is_div = 1'b0; flush = 1'b1;
      #1;
      tests++; if (stall !== 1'b0) begin fails++; $display("[TB] FAIL flush_idle_stall: got %b, expected 0", stall); end
      @(negedge clock);
      issue_valid = 1'b0; flush = 1'b0;
      #1;
      tests++; if ({issue_ready, md_ctrl_MULT, md_ctrl_DIV} !== 3'b100) begin fails++;
         $display("[TB] FAIL flush_idle_accept: got %b, expected 100", {issue_ready, md_ctrl_MULT, md_ctrl_DIV}); end
   endtask

   task automatic test_back_to_back();
      int lat, wbc, st, mc, dc, pc; bit held; logic [31:0] d; logic [4:0] r; logic e, rdy;
      do_op(0, 32'd11, 32'd13, 5'd20, 0, 60, lat, wbc, st, mc, dc, pc, held, d, r, e, rdy);
      tests++; if ({lat, r, d} !== {32'd18, 5'd20, 32'd143}) begin fails++;
         $display("[TB] FAIL b2b_first: got lat=%0d rd=%0d data=%h, expected 18 20 0000008f", lat, r, d); end
      do_op(1, 32'hFFFF_FF9C, 32'd7, 5'd31, 0, 80, lat, wbc, st, mc, dc, pc, held, d, r, e, rdy);
      tests++; if ({lat, r, d, e} !== {32'd34, 5'd31, 32'hFFFF_FFF2, 1'b0}) begin fails++;
         $display("[TB] FAIL b2b_second: got lat=%0d rd=%0d data=%h exc=%b, expected 34 31 fffffff2 0", lat, r, d, e); end
   endtask

   task automatic test_reset_mid_wait();
      int lat, wbc, st, mc, dc, pc; bit held; logic [31:0] d; logic [4:0] r; logic e, rdy;
      int strays;
      do_op(1, 32'd81, 32'd9, 5'd6, 0, 10, lat, wbc, st, mc, dc, pc, held, d, r, e, rdy);
      #1;
      reset_n = 1'b0;
      #1;
      tests++; if ({md_operandA, md_operandB, wb_data, wb_rd, wb_valid, wb_exception} !== '0) begin fails++;
         $display("[TB] FAIL reset_mid_outputs: got %h %h %h %h %b %b, expected all 0", md_operandA, md_operandB, wb_data, wb_rd, wb_valid, wb_exception); end
      tests++; if ({issue_ready, stall} !== 2'b10) begin fails++; $display("[TB] FAIL reset_mid_state: got %b, expected 10", {issue_ready, stall}); end
      @(negedge clock);
      reset_n = 1'b1;
      strays = 0;
      for (int i = 0; i < 40; i++) begin
         forceRdy = (i == 3);
         #1;
         if (wb_valid !== 1'b0) strays++;
         @(negedge clock);
      end
      forceRdy = 1'b0;
      #1;
      tests++; if (strays !== 0 || issue_ready !== 1'b1) begin fails++;
         $display("[TB] FAIL stray_ready: got %0d strobes ready=%b, expected 0 1", strays, issue_ready); end
   endtask

`ifdef MULTDIV_TIMEOUT_EN
   task automatic test_timeout();
      int lat, wbc, st, mc, dc, pc; bit held; logic [31:0] d; logic [4:0] r; logic e, rdy;
      stubMute = 1;
      do_op(1, 32'd10, 32'd2, 5'd7, 0, 80, lat, wbc, st, mc, dc, pc, held, d, r, e, rdy);
      stubMute = 0;
      tests++; if ({lat, e, d, r} !== {32'd43, 1'b1, 32'd0, 5'd7}) begin fails++;
         $display("[TB] FAIL timeout_wb: got lat=%0d exc=%b data=%h rd=%0d, expected 43 1 0 7", lat, e, d, r); end
      #1;
      tests++; if (timeout_seen !== 1'b1) begin fails++; $display("[TB] FAIL timeout_seen: got %b, expected 1", timeout_seen); end
   endtask
`endif

   initial begin
      issue_valid = 1'b0; issue_is_div = 1'b0; issue_opA = '0; issue_opB = '0; issue_rd = '0; flush = 1'b0;
      test_reset();
      test_mult();
      test_flush_vs_ready();
      test_div();
      test_exceptions();
      test_flush_wait();
      test_flush_done();
      test_flush_idle();
      test_back_to_back();
`ifdef MULTDIV_TIMEOUT_EN
      test_timeout();
`endif
      test_reset_mid_wait();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
